// File: rtl/piso_pkg.sv
// Types and constants shared by the parallel-in serial-out serializer and its bit counter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Clearable, enabled bit counter for one serial frame; saturates at WIDTH-1 and flags it.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] count_reg;

  // Clear wins over enable so a reload on the last bit restarts the frame at 0.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && !terminal) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count    = count_reg;
  assign terminal = (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with load/shift handshakes, frame markers and gapless reload.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] datain,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;
  logic [CW-1:0]    bit_count;
  logic             last_bit;
  logic             in_shift;
  logic             load_hs;
  logic             bit_xfer;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit = shift_reg[WIDTH-1];
      assign shifted = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit = shift_reg[0];
      assign shifted = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  assign in_shift = (state_reg == SHIFT);
  // A new word is taken when idle, or on the final bit transfer for back-to-back frames.
  assign load_ready = !reset && (!in_shift || (last_bit && shift_en));
  assign load_hs    = load_valid && load_ready;
  assign bit_xfer   = in_shift && shift_en;

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (load_hs),
    .enable  (bit_xfer),
    .count   (bit_count),
    .terminal(last_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load_hs) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_xfer && last_bit && !load_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (load_hs) begin
      shift_reg <= datain;
    end else if (bit_xfer && !last_bit) begin
      shift_reg <= shifted;
    end
  end

  // Every serial-side output is a function of registered state only.
  assign sout_valid  = in_shift;
  assign busy        = in_shift;
  assign sout        = in_shift && out_bit;
  assign frame_start = in_shift && (bit_count == '0);
  assign frame_end   = in_shift && last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: MSB-first and LSB-first 8-bit serializers plus a 3-bit one, checked bit by bit.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic fs;
    logic fe;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [7:0] din8;
  logic [2:0] din3;
  logic       lv8;
  logic       lv3;
  logic       se;
  logic [2:0] lr;
  logic [2:0] so;
  logic [2:0] sv;
  logic [2:0] fs;
  logic [2:0] fe;
  logic [2:0] bz;

  exp_t exp_q [3][$];
  int   n_cmp = 0;
  int   n_err = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clock(clock), .reset(reset), .datain(din8), .load_valid(lv8), .load_ready(lr[0]),
    .shift_en(se), .sout(so[0]), .sout_valid(sv[0]), .frame_start(fs[0]),
    .frame_end(fe[0]), .busy(bz[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .datain(din8), .load_valid(lv8), .load_ready(lr[1]),
    .shift_en(se), .sout(so[1]), .sout_valid(sv[1]), .frame_start(fs[1]),
    .frame_end(fe[1]), .busy(bz[1])
  );

  piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b1)) dut_w3 (
    .clock(clock), .reset(reset), .datain(din3), .load_valid(lv3), .load_ready(lr[2]),
    .shift_en(se), .sout(so[2]), .sout_valid(sv[2]), .frame_start(fs[2]),
    .frame_end(fe[2]), .busy(bz[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input int d, input int w, input bit msb, input logic [7:0] data);
    for (int i = 0; i < w; i++) begin
      exp_t e;
      e.b  = msb ? data[w-1-i] : data[i];
      e.fs = (i == 0);
      e.fe = (i == w - 1);
      exp_q[d].push_back(e);
    end
  endtask

  task automatic check_idle8(input string tag);
    @(negedge clock);
    check_value({tag, "_valid"}, {30'd0, sv[1:0]}, 32'd0);
    check_value({tag, "_busy"}, {30'd0, bz[1:0]}, 32'd0);
    check_value({tag, "_ready"}, {30'd0, lr[1:0]}, 32'd3);
    check_value({tag, "_qmsb"}, exp_q[0].size(), 32'd0);
    check_value({tag, "_qlsb"}, exp_q[1].size(), 32'd0);
  endtask

  // Scoreboard: every valid serial bit must match the head of its queue; popped on transfer.
  always @(negedge clock) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (sv[d]) begin
          if (exp_q[d].size() == 0) begin
            check_value($sformatf("d%0d_extra_bit", d), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q[d][0];
            check_value($sformatf("d%0d_bit{sout,fs,fe}", d), {29'd0, so[d], fs[d], fe[d]},
                        {29'd0, e});
            if (se) void'(exp_q[d].pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    din8  = 8'h00;
    din3  = 3'b000;
    lv8   = 1'b0;
    lv3   = 1'b0;
    se    = 1'b1;

    repeat (3) tick();
    @(negedge clock);
    check_value("rst_ready", {29'd0, lr}, 32'd0);
    check_value("rst_valid", {29'd0, sv}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_value("post_rst_ready", {29'd0, lr}, 32'd7);
    check_value("post_rst_busy", {29'd0, bz}, 32'd0);
    check_value("post_rst_sout", {29'd0, so | fs | fe}, 32'd0);

    // A5 on both 8-bit instances, 010 on the 3-bit instance, shift_en held high.
    tick();
    lv8 = 1'b1; din8 = 8'hA5; lv3 = 1'b1; din3 = 3'b010;
    push_word(0, 8, 1'b1, 8'hA5);
    push_word(1, 8, 1'b0, 8'hA5);
    push_word(2, 3, 1'b1, 8'h02);
    tick();
    lv8 = 1'b0; lv3 = 1'b0; din8 = 8'h3C; din3 = 3'b111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check_value($sformatf("a5_busy_k%0d", k), {31'd0, bz[0]}, 32'd1);
      check_value($sformatf("w3_busy_k%0d", k), {31'd0, bz[2]}, (k < 3) ? 32'd1 : 32'd0);
      tick();
    end
    check_idle8("a5_end");
    check_value("w3_q_empty", exp_q[2].size(), 32'd0);

    // 01: single set bit exercises shift direction and zero fill.
    tick();
    lv8 = 1'b1; din8 = 8'h01;
    push_word(0, 8, 1'b1, 8'h01);
    push_word(1, 8, 1'b0, 8'h01);
    tick();
    lv8 = 1'b0;
    repeat (8) tick();
    check_idle8("x01_end");

    // F0 with a three-cycle stall after bit 2.
    tick();
    lv8 = 1'b1; din8 = 8'hF0;
    push_word(0, 8, 1'b1, 8'hF0);
    push_word(1, 8, 1'b0, 8'hF0);
    tick();
    lv8 = 1'b0;
    repeat (2) tick();
    se = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_value($sformatf("stall_ready_k%0d", k), {30'd0, lr[1:0]}, 32'd0);
      check_value($sformatf("stall_q_k%0d", k), exp_q[0].size(), 32'd6);
      tick();
    end
    se = 1'b1;
    repeat (6) tick();
    check_idle8("stall_end");

    // Back-to-back: FF then 00 with load_valid held high.
    tick();
    lv8 = 1'b1; din8 = 8'hFF;
    push_word(0, 8, 1'b1, 8'hFF);
    push_word(1, 8, 1'b0, 8'hFF);
    tick();
    din8 = 8'h00;
    push_word(0, 8, 1'b1, 8'h00);
    push_word(1, 8, 1'b0, 8'h00);
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      check_value($sformatf("b2b_ready_k%0d", k), {31'd0, lr[0]}, 32'd0);
      tick();
    end
    @(negedge clock);
    check_value("b2b_ready_last", {31'd0, lr[0]}, 32'd1);
    tick();
    lv8 = 1'b0;
    @(negedge clock);
    check_value("b2b_next_frame", {29'd0, sv[0], fs[0], so[0]}, 32'b110);
    repeat (8) tick();
    check_idle8("b2b_end");

    // Reset after bit 4 of C3 abandons the frame.
    tick();
    lv8 = 1'b1; din8 = 8'hC3;
    push_word(0, 8, 1'b1, 8'hC3);
    push_word(1, 8, 1'b0, 8'hC3);
    tick();
    lv8 = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    @(negedge clock);
    check_value("mid_rst_ready_comb", {31'd0, lr[0]}, 32'd0);
    tick();
    @(negedge clock);
    check_value("mid_rst_state", {29'd0, sv[0], bz[0], lr[0]}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_value("rel_ready", {31'd0, lr[0]}, 32'd1);
    repeat (4) tick();
    check_idle8("rel_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 shifted first, 0 = bit 0 shifted first.
REQ-003 Reset is reset, synchronous, active-high; clock is clock.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 datain  input  WIDTH  parallel word, sampled on load handshake.
REQ-007 load_valid  input  1  upstream offers datain.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 shift_en  input  1  downstream accepts the current serial bit; low stalls shifting.
REQ-010 sout  output  1  current serial bit.
REQ-011 sout_valid  output  1  sout carries a frame bit.
REQ-012 frame_start  output  1  high with the first bit of a frame.
REQ-013 frame_end  output  1  high with the last bit of a frame.
REQ-014 busy  output  1  high while a frame is in progress.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-016 Load handshake SHALL occur on a rising edge where load_valid and load_ready are both high; datain is then copied into the shift register and the bit counter is cleared to 0.
REQ-017 Bit transfer SHALL occur on a rising edge where sout_valid and shift_en are both high.
REQ-018 In IDLE: load_ready = 1 (except during reset), sout_valid = 0, busy = 0, sout = 0, frame_start = 0, frame_end = 0.
REQ-019 IDLE -> SHIFT on load handshake; the first bit SHALL appear on sout, with sout_valid = 1, in the cycle after the handshake (latency 1).
REQ-020 In SHIFT: sout_valid = 1 and busy = 1; sout = shift-register bit selected by MSB_FIRST.
REQ-021 frame_start SHALL be 1 exactly when in SHIFT with counter = 0.
REQ-022 frame_end SHALL be 1 exactly when in SHIFT with counter = WIDTH-1.
REQ-023 On each bit transfer with counter < WIDTH-1: shift the register one position toward the output end, fill with 0, and increment the counter.
REQ-024 With shift_en low in SHIFT: sout, counter, frame_start and frame_end SHALL hold unchanged; there is no timeout.
REQ-025 In SHIFT, load_ready = 1 only when counter = WIDTH-1 and shift_en = 1; otherwise 0.
REQ-026 Bit transfer at counter = WIDTH-1 with a simultaneous load handshake: stay in SHIFT, load the new word, clear the counter; the next cycle shows the new frame's first bit (gapless back-to-back).
REQ-027 Bit transfer at counter = WIDTH-1 without a load handshake: go to IDLE.
REQ-028 datain changes outside a load handshake SHALL have no effect.
REQ-029 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-030 sout, sout_valid, frame_start, frame_end and busy SHALL be driven from registered state only, with no combinational path from inputs.

Reset
REQ-031 While reset is high at a rising edge, the block SHALL enter IDLE and clear the shift register and counter to 0.
REQ-032 After that edge: sout = 0, sout_valid = 0, frame_start = 0, frame_end = 0, busy = 0.
REQ-033 load_ready SHALL be 0 while reset is high.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; no remaining bits are emitted after reset is released.
REQ-035 Reset SHALL take priority over a simultaneous load handshake or bit transfer.

Structure
REQ-036 A shared package piso_pkg SHALL hold the state enumeration (IDLE, SHIFT) and the default WIDTH constant.
REQ-037 One sub-module, piso_bit_counter, SHALL implement the clearable, enabled counter with a terminal-count flag (counter = WIDTH-1).
REQ-038 The shift register and FSM SHALL reside in piso_serializer.

Verification
REQ-039 WIDTH=8, MSB_FIRST=1, load 8'hA5, shift_en held 1 -> sout = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_start on bit 1, frame_end on bit 8; then IDLE.
REQ-040 MSB_FIRST=0, load 8'hA5 -> sout = 1,0,1,0,0,1,0,1 reversed-order check (LSB first: 1,0,1,0,0,1,0,1 for A5 read from bit 0), and 8'h01 -> sout = 1,0,0,0,0,0,0,0.
REQ-041 Load 8'hF0, drop shift_en for 3 cycles after bit 2 -> sout, frame flags and counter hold for 3 cycles, then bits 3..8 continue; 8 transfers total.
REQ-042 Back-to-back: load 8'hFF, keep load_valid=1 with datain=8'h00 -> load_ready pulses on bit 8, next cycle frame_start=1 with sout=0, no idle cycle.
REQ-043 Reset asserted after bit 4 of 8'hC3 -> next cycle sout_valid=0, busy=0, load_ready=0; after release, load_ready=1 and no residual bits appear.
REQ-044 WIDTH=3, load 3'b010 -> sout = 0,1,0; frame_start and frame_end on separate cycles 1 and 3; busy high exactly 3 cycles.
